// File: rtl/bcd_seg7_display.sv
// Iterative double-dabble binary-to-BCD converter with a start/busy/done handshake.
// The held result is scanned onto a time-multiplexed common-segment 7-segment display.
module bcd_seg7_display #(
    parameter int WIDTH          = 8,
    parameter int DIGITS         = 3,
    parameter int SCAN_DIV       = 1024,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int BLANK_LEADING  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic                ovf,
    output logic [4*DIGITS-1:0] bcd,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   an
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {IDLE, CONVERT} state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              scr_q, scr_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic [BW-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     scan_q, scan_d;
    logic [IW-1:0]     idx_q, idx_d;

    logic [BW-1:0]     acc_adj;
    logic [BW-1:0]     acc_shift;
    logic              carry_out;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign acc_adj[4*gi +: 4] = (acc_q[4*gi +: 4] >= 4'd5) ? acc_q[4*gi +: 4] + 4'd3
                                                                  : acc_q[4*gi +: 4];
        end
    endgenerate

    assign acc_shift = {acc_adj[BW-2:0], shift_q[WIDTH-1]};
    assign carry_out = acc_adj[BW-1];

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        scr_d   = scr_q;
        bcd_d   = bcd_q;
        acc_d   = acc_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = bin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    scr_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                acc_d   = acc_shift;
                shift_d = shift_q << 1;
                scr_d   = scr_q | carry_out;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    bcd_d   = acc_shift;
                    ovf_d   = scr_q | carry_out;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Digit scan is free-running and deliberately independent of conversions.
    always_comb begin
        scan_d = scan_q + 1'b1;
        idx_d  = idx_q;
        if (scan_q == SW'(SCAN_DIV - 1)) begin
            scan_d = '0;
            idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            scr_q   <= 1'b0;
            bcd_q   <= '0;
            acc_q   <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            scan_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            scr_q   <= scr_d;
            bcd_q   <= bcd_d;
            acc_q   <= acc_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;
    assign bcd  = bcd_q;

    logic [3:0]        digit_arr [DIGITS];
    logic [DIGITS:1]   lead_zero;
    logic [DIGITS-1:0] blank_vec;

    // lead_zero[i]: digits i..DIGITS-1 are all zero.
    assign lead_zero[DIGITS] = 1'b1;
    assign blank_vec[0]      = 1'b0;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_dig
            assign digit_arr[gi] = bcd_q[4*gi +: 4];
        end
        for (gi = 1; gi < DIGITS; gi++) begin : g_blank
            assign lead_zero[gi] = (bcd_q[4*gi +: 4] == 4'd0) && lead_zero[gi+1];
            assign blank_vec[gi] = (BLANK_LEADING != 0) && lead_zero[gi];
        end
    endgenerate

    logic [3:0]        cur_digit;
    logic [6:0]        seg_hi;
    logic [DIGITS-1:0] an_hi;

    assign cur_digit = digit_arr[idx_q];

    always_comb begin
        case (cur_digit)
            4'd0:    seg_hi = 7'h3F;
            4'd1:    seg_hi = 7'h06;
            4'd2:    seg_hi = 7'h5B;
            4'd3:    seg_hi = 7'h4F;
            4'd4:    seg_hi = 7'h66;
            4'd5:    seg_hi = 7'h6D;
            4'd6:    seg_hi = 7'h7D;
            4'd7:    seg_hi = 7'h07;
            4'd8:    seg_hi = 7'h7F;
            4'd9:    seg_hi = 7'h6F;
            default: seg_hi = 7'h00;
        endcase
        if (blank_vec[idx_q]) seg_hi = 7'h00;
    end

    assign an_hi = DIGITS'(1) << idx_q;
    assign seg   = (SEG_ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
    assign an    = (SEG_ACTIVE_LOW != 0) ? ~an_hi : an_hi;
endmodule

// File: tb/tb_bcd_seg7_display.sv
// Bench for bcd_seg7_display: three instances (3 digits, 2 digits, no leading blanking)
// share stimulus; a queue scoreboard checks every done pulse.
module tb_bcd_seg7_display;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  bin = '0;

    logic        busy_a, done_a, ovf_a;
    logic [11:0] bcd_a;
    logic [6:0]  seg_a;
    logic [2:0]  an_a;
    logic        busy_b, done_b, ovf_b;
    logic [7:0]  bcd_b;
    logic [6:0]  seg_b;
    logic [1:0]  an_b;
    logic        busy_c, done_c, ovf_c;
    logic [11:0] bcd_c;
    logic [6:0]  seg_c;
    logic [2:0]  an_c;

    always #5 clk = ~clk;

    bcd_seg7_display #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1), .BLANK_LEADING(1)) u_a (
        .clk(clk), .rst(rst), .start(start), .bin(bin), .busy(busy_a), .done(done_a),
        .ovf(ovf_a), .bcd(bcd_a), .seg(seg_a), .an(an_a));
    bcd_seg7_display #(.WIDTH(8), .DIGITS(2), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1), .BLANK_LEADING(1)) u_b (
        .clk(clk), .rst(rst), .start(start), .bin(bin), .busy(busy_b), .done(done_b),
        .ovf(ovf_b), .bcd(bcd_b), .seg(seg_b), .an(an_b));
    bcd_seg7_display #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1), .BLANK_LEADING(0)) u_c (
        .clk(clk), .rst(rst), .start(start), .bin(bin), .busy(busy_c), .done(done_c),
        .ovf(ovf_c), .bcd(bcd_c), .seg(seg_c), .an(an_c));

    typedef struct {
        logic [11:0] bcd3;
        logic        ovf3;
        logic [7:0]  bcd2;
        logic        ovf2;
    } exp_t;

    typedef struct {
        logic [7:0] bin;
        exp_t       e;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done_a) begin
            exp_t e;
            done_cnt++;
            chk("done_b_align", {31'd0, done_b}, 32'd1);
            chk("done_c_align", {31'd0, done_c}, 32'd1);
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                $display("done: bcd_a=%03h ovf_a=%0b bcd_b=%02h ovf_b=%0b", bcd_a, ovf_a, bcd_b, ovf_b);
                chk("bcd3", {20'd0, bcd_a}, {20'd0, e.bcd3});
                chk("ovf3", {31'd0, ovf_a}, {31'd0, e.ovf3});
                chk("bcd2", {24'd0, bcd_b}, {24'd0, e.bcd2});
                chk("ovf2", {31'd0, ovf_b}, {31'd0, e.ovf2});
                chk("bcd3_noblank", {20'd0, bcd_c}, {20'd0, e.bcd3});
                chk("ovf3_noblank", {31'd0, ovf_c}, {31'd0, e.ovf3});
            end
        end
    end

    task automatic run_conv(input vec_t v);
        @(negedge clk);
        bin   = v.bin;
        start = 1'b1;
        sb.push_back(v.e);
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("busy_during", {31'd0, busy_a}, 32'd1);
            chk("done_early", {31'd0, done_a}, 32'd0);
        end
        @(negedge clk);
        chk("done_latency", {31'd0, done_a}, 32'd1);
        chk("busy_after", {29'd0, busy_a, busy_b, busy_c}, 32'd0);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done_a}, 32'd0);
    endtask

    // ea/ec hold active-high expected patterns {digit2, digit1, digit0}.
    task automatic check_scan(input logic [20:0] ea, input logic [20:0] ec);
        bit found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (an_a != 3'b110) found = 1;
        end
        chk("scan_leave0", {31'd0, found}, 32'd1);
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (an_a == 3'b110) found = 1;
        end
        chk("scan_enter0", {31'd0, found}, 32'd1);
        for (int p = 0; p < 12; p++) begin
            int d;
            logic [2:0] an_exp;
            d = p / 4;
            an_exp = ~(3'b001 << d);
            chk("an_a", {29'd0, an_a}, {29'd0, an_exp});
            chk("an_c", {29'd0, an_c}, {29'd0, an_exp});
            chk("seg_a", {25'd0, seg_a}, {25'd0, ~ea[d*7 +: 7]});
            chk("seg_c", {25'd0, seg_c}, {25'd0, ~ec[d*7 +: 7]});
            @(negedge clk);
        end
        chk("scan_repeat", {29'd0, an_a}, 32'd6);
    endtask

    vec_t vecs[6];
    vec_t v;
    int   dc0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{bin: 8'd255, e: '{12'h255, 1'b0, 8'h55, 1'b1}};
        vecs[1] = '{bin: 8'd200, e: '{12'h200, 1'b0, 8'h00, 1'b1}};
        vecs[2] = '{bin: 8'd99,  e: '{12'h099, 1'b0, 8'h99, 1'b0}};
        vecs[3] = '{bin: 8'd17,  e: '{12'h017, 1'b0, 8'h17, 1'b0}};
        vecs[4] = '{bin: 8'd100, e: '{12'h100, 1'b0, 8'h00, 1'b1}};
        vecs[5] = '{bin: 8'd250, e: '{12'h250, 1'b0, 8'h50, 1'b1}};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_ovf", {31'd0, ovf_a}, 32'd0);
        chk("rst_bcd", {20'd0, bcd_a}, 32'd0);
        chk("rst_an_a", {29'd0, an_a}, 32'd6);
        chk("rst_seg_a", {25'd0, seg_a}, 32'h40);
        chk("rst_an_b", {30'd0, an_b}, 32'd2);
        chk("rst_seg_b", {25'd0, seg_b}, 32'h40);

        for (int i = 0; i < 6; i++) begin
            $display("vector %0d: bin=%0d", i, vecs[i].bin);
            run_conv(vecs[i]);
        end

        // start while busy must be ignored
        dc0 = done_cnt;
        sb.push_back(vecs[3].e);
        @(negedge clk);
        bin = 8'd17; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);
        bin = 8'd42; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (12) @(negedge clk);
        chk("ignore_single_done", done_cnt - dc0, 32'd1);
        chk("ignore_bcd", {20'd0, bcd_a}, 32'h017);
        $display("ignore-busy-start: bcd_a=%03h", bcd_a);

        // asynchronous reset mid-conversion
        @(negedge clk);
        bin = 8'd255; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy_a}, 32'd0);
        chk("abort_bcd", {20'd0, bcd_a}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dc0 = done_cnt;
        repeat (12) @(negedge clk);
        chk("abort_no_done", done_cnt - dc0, 32'd0);
        chk("abort_bcd_held", {20'd0, bcd_a}, 32'd0);
        $display("reset-abort: bcd_a=%03h", bcd_a);
        run_conv(vecs[0]);

        // start accepted in the done cycle
        @(negedge clk);
        bin = 8'd5; start = 1'b1;
        sb.push_back('{12'h005, 1'b0, 8'h05, 1'b0});
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(negedge clk);
        @(negedge clk);
        chk("chain_done1", {31'd0, done_a}, 32'd1);
        bin = 8'd99; start = 1'b1;
        sb.push_back(vecs[2].e);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(negedge clk);
        @(negedge clk);
        chk("chain_done2", {31'd0, done_a}, 32'd1);
        $display("done-cycle start: bcd_a=%03h", bcd_a);

        v = '{bin: 8'd42, e: '{12'h042, 1'b0, 8'h42, 1'b0}};
        run_conv(v);
        check_scan({7'h00, 7'h66, 7'h5B}, {7'h3F, 7'h66, 7'h5B});
        $display("scan 042 checked");

        v = '{bin: 8'd0, e: '{12'h000, 1'b0, 8'h00, 1'b0}};
        run_conv(v);
        check_scan({7'h00, 7'h00, 7'h3F}, {7'h3F, 7'h3F, 7'h3F});
        $display("scan 000 checked");

        chk("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
